jt49_period_meter: RTL and testbench
====================================

// Module: jt49_period_meter
// PURPOSE
//  Inverse of the tone/noise/envelope divider: measures the spacing, in cen-qualified clk cycles,
//  between successive one-sample event strobes (e.g. a divider's cen_div) and reports it as a period word.
//  Used to check divider programming in-system and to recover the period of an external tone source.
//  Sits next to the dividers, in the same divided-clock (cen) domain.
// PARAMETERS
//  width  12  width of the period counter and the period output; maximum measurable period is 2^width-1
// PORTS
//  clk      in   1      clock
//  rst_n    in   1      reset, synchronous, active-low
//  cen      in   1      clock enable; all state advances only on clk rising edges with cen=1
//  tick     in   1      event strobe; sampled only when cen=1; high on exactly one cen sample per event
//  period   out  width  last accepted period; 0 = no valid measurement
//  valid    out  1      period holds a valid measurement
//  upd      out  1      one-clk pulse: period/valid were written on this edge
//  ovf      out  1      one-clk pulse: counter saturated without an event (source stopped or period 0)
// BEHAVIOUR
//  Reset: period=0, valid=0, upd=0, ovf=0, cnt=1, state=IDLE. Reset mid-measurement discards everything.
//  upd/ovf are cleared on every clk edge where they are not set, regardless of cen.
//  event = cen & tick. With cen=0: cnt, state and outputs (except upd/ovf clearing) hold; tick is ignored.
//  cnt: on event, cnt<=1; otherwise, on cen, cnt<=cnt+1. Events every P cen samples give a measurement of P (P=1 allowed).
//  States:
//   IDLE   -- event -> ARMED, cnt<=1, no capture (first edge has no reference).
//   ARMED  -- event -> measurement m=cnt; accept (see CONFIGURATION); cnt<=1.
//   LOCKED -- event -> measurement m=cnt; accept; stay LOCKED.
//  Accept m: period<=m, valid<=1, upd<=1 on the same edge as the event; visible 1 clk later.
//  Saturation: in ARMED/LOCKED, cen & ~tick & cnt=={width{1}} -> state IDLE, period<=0, valid<=0,
//   ovf<=1, upd<=1, cnt<=1. In IDLE, cnt holds at 1 (never saturates).
//  Simultaneous event and cnt==all-ones: the event wins; m=2^width-1 is accepted as a normal measurement.
//  All arithmetic is unsigned, width bits; cnt never wraps.
// CONFIGURATION
//  JT49_PERIOD_MATCH_EN defined: adds a CHECK state and a width-bit candidate register.
//   ARMED event -> cand<=m, go CHECK. CHECK event: m==cand -> accept m, go LOCKED; else cand<=m, stay CHECK.
//   LOCKED event with m!=period -> cand<=m, go CHECK; period/valid keep the old value; no upd pulse.
//   LOCKED event with m==period -> no change, no upd pulse.
//   Saturation from CHECK behaves as from ARMED/LOCKED.
//  Not defined: no CHECK state and no cand register; every measurement is accepted immediately.
// STRUCTURE
//  jt49_pkg (shared): state encodings ST_IDLE/ST_ARMED/ST_CHECK/ST_LOCKED; helpers ONE(width), ALL1(width).
//  Sub-module jt49_period_cnt: saturating cen counter with sync clear, all-ones flag and hold at 1 while disabled.
//  Top: FSM, optional candidate compare, output registers.
// TESTING
//  1. width=12, tick every 5th cen sample, cen=1 always -> first upd after 2nd event, period=5, valid=1.
//  2. tick held high with cen=1 every clk (P=1) -> period=1, upd pulses every clk after the 2nd event.
//  3. width=4, lock at P=3, then stop tick -> after 15 further cen samples: ovf=1, upd=1, period=0, valid=0, state IDLE.
//  4. cen high 1 clk in 3, events every 4 cen samples, tick also pulsed while cen=0 -> period=4; cen=0 pulses ignored.
//  5. JT49_PERIOD_MATCH_EN: gaps 5,6,6 -> period updates to 6 only at the 3rd gap; a stray gap of 7 then 6
//     -> period stays 6, no upd pulse.
//  6. rst_n low for 1 clk mid-count while LOCKED at 9 -> period=0, valid=0; next upd only after 2 new events.

Source files
------------

// File: rtl/jt49_pkg.sv
// Shared JT49 definitions: measurement FSM state encodings and width helpers.
package jt49_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } jt49_state_t;

    function automatic int unsigned ONE(input int unsigned w);
        ONE = (w > 0) ? 32'd1 : 32'd0;
    endfunction

    function automatic int unsigned ALL1(input int unsigned w);
        ALL1 = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/jt49_period_cnt.sv
// Saturating cen-qualified period counter: sync clear to 1, held at 1 while disabled,
// all-ones flag for the saturation detect in the owner FSM.
module jt49_period_cnt
    import jt49_pkg::*;
#(
    parameter int unsigned width = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cen,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [width-1:0] o_cnt,
    output logic             o_all1
);

    localparam logic [width-1:0] CntOne  = width'(ONE(width));
    localparam logic [width-1:0] CntAll1 = width'(ALL1(width));

    logic [width-1:0] r_cnt;
    logic [width-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_cen) begin
            if (i_clr || !i_en) begin
                w_cnt_d = CntOne;
            end else if (r_cnt != CntAll1) begin
                // Saturation itself is resolved by the owner via i_clr; never wrap here.
                w_cnt_d = r_cnt + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= CntOne;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_all1 = (r_cnt == CntAll1);

endmodule

// File: rtl/jt49_period_meter.sv
// Measures the spacing between cen-qualified tick strobes and reports it as a period word.
// Define JT49_PERIOD_MATCH_EN to require two equal consecutive gaps before accepting a period.
module jt49_period_meter
    import jt49_pkg::*;
#(
    parameter int unsigned width = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             tick,
    output logic [width-1:0] period,
    output logic             valid,
    output logic             upd,
    output logic             ovf
);

    jt49_state_t      r_state, w_state_d;
    logic [width-1:0] r_period, w_period_d;
    logic             r_valid, w_valid_d;
    logic             r_upd, w_upd_d;
    logic             r_ovf, w_ovf_d;
    logic [width-1:0] w_cnt;
    logic             w_all1;
    logic             w_event;
    logic             w_sat;
`ifdef JT49_PERIOD_MATCH_EN
    logic [width-1:0] r_cand, w_cand_d;
`endif

    assign w_event = cen & tick;
    // An event on the all-ones sample wins over saturation.
    assign w_sat   = cen & ~tick & w_all1 & (r_state != ST_IDLE);

    jt49_period_cnt #(
        .width (width)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cen  (cen),
        .i_en   (r_state != ST_IDLE),
        .i_clr  (w_event | w_sat),
        .o_cnt  (w_cnt),
        .o_all1 (w_all1)
    );

    always_comb begin
        w_state_d  = r_state;
        w_period_d = r_period;
        w_valid_d  = r_valid;
        w_upd_d    = 1'b0;
        w_ovf_d    = 1'b0;
`ifdef JT49_PERIOD_MATCH_EN
        w_cand_d   = r_cand;
`endif
        if (w_sat) begin
            w_state_d  = ST_IDLE;
            w_period_d = '0;
            w_valid_d  = 1'b0;
            w_upd_d    = 1'b1;
            w_ovf_d    = 1'b1;
        end else if (w_event) begin
            case (r_state)
                ST_IDLE: w_state_d = ST_ARMED;
`ifdef JT49_PERIOD_MATCH_EN
                ST_ARMED: begin
                    w_cand_d  = w_cnt;
                    w_state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_cnt == r_cand) begin
                        w_period_d = w_cnt;
                        w_valid_d  = 1'b1;
                        w_upd_d    = 1'b1;
                        w_state_d  = ST_LOCKED;
                    end else begin
                        w_cand_d = w_cnt;
                    end
                end
                ST_LOCKED: begin
                    if (w_cnt != r_period) begin
                        w_cand_d  = w_cnt;
                        w_state_d = ST_CHECK;
                    end
                end
`else
                ST_ARMED, ST_LOCKED: begin
                    w_period_d = w_cnt;
                    w_valid_d  = 1'b1;
                    w_upd_d    = 1'b1;
                    w_state_d  = ST_LOCKED;
                end
`endif
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_upd    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_period <= w_period_d;
            r_valid  <= w_valid_d;
            r_upd    <= w_upd_d;
            r_ovf    <= w_ovf_d;
        end
    end

`ifdef JT49_PERIOD_MATCH_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cand <= '0;
        end else begin
            r_cand <= w_cand_d;
        end
    end
`endif

    assign period = r_period;
    assign valid  = r_valid;
    assign upd    = r_upd;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_jt49_period_meter.sv
// Scoreboard bench for jt49_period_meter: two instances (width 12 and 4) share stimulus.
module tb_jt49_period_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        tick;
    logic [11:0] period_a;
    logic        valid_a, upd_a, ovf_a;
    logic [3:0]  period_b;
    logic        valid_b, upd_b, ovf_b;

    always #5 clk = ~clk;

    jt49_period_meter #(.width(12)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cen(cen), .tick(tick),
        .period(period_a), .valid(valid_a), .upd(upd_a), .ovf(ovf_a)
    );

    jt49_period_meter #(.width(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cen(cen), .tick(tick),
        .period(period_b), .valid(valid_b), .upd(upd_b), .ovf(ovf_b)
    );

    typedef struct {
        int per;
        bit val;
        bit ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    localparam int MIdle = 0, MArmed = 1, MCheck = 2, MLocked = 3;
    int n_cen;
    int m_st[2], m_last[2], m_per[2], m_cand[2];
    bit m_val[2];
    int wid[2] = '{12, 4};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input int i, input int per, input bit val, input bit ov);
        exp_t e;
        e.per = per;
        e.val = val;
        e.ovf = ov;
        if (i == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic accept(input int i, input int m);
        m_per[i] = m;
        m_val[i] = 1'b1;
        m_st[i]  = MLocked;
        push(i, m, 1'b1, 1'b0);
    endtask

    // Reference: periods are differences of cen-sample indices between accepted strobes.
    task automatic model_step();
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i]   = MIdle;
                m_per[i]  = 0;
                m_val[i]  = 1'b0;
                m_cand[i] = 0;
                m_last[i] = 0;
            end
            n_cen = 0;
        end else if (cen) begin
            for (int i = 0; i < 2; i++) begin
                int maxv;
                int m;
                maxv = (1 << wid[i]) - 1;
                m    = n_cen - m_last[i];
                if (m_st[i] == MIdle) begin
                    if (tick) begin
                        m_st[i]   = MArmed;
                        m_last[i] = n_cen;
                    end
                end else if (tick) begin
                    m_last[i] = n_cen;
`ifdef JT49_PERIOD_MATCH_EN
                    if (m_st[i] == MArmed) begin
                        m_cand[i] = m;
                        m_st[i]   = MCheck;
                    end else if (m_st[i] == MCheck) begin
                        if (m == m_cand[i]) accept(i, m);
                        else m_cand[i] = m;
                    end else if (m != m_per[i]) begin
                        m_cand[i] = m;
                        m_st[i]   = MCheck;
                    end
`else
                    accept(i, m);
`endif
                end else if (m == maxv) begin
                    m_st[i]  = MIdle;
                    m_per[i] = 0;
                    m_val[i] = 1'b0;
                    push(i, 0, 1'b0, 1'b1);
                end
            end
            n_cen++;
        end
    endtask

    task automatic mon(input int i, input string tag, input logic [31:0] per, input logic val,
                       input logic up, input logic ov);
        exp_t e;
        int   qs;
        qs = (i == 0) ? q_a.size() : q_b.size();
        check({tag, "_period"}, per, m_per[i]);
        check({tag, "_valid"}, {31'd0, val}, {31'd0, m_val[i]});
        if (up === 1'b1) begin
            if (qs == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_spurious_upd: got upd=1 expected upd=0 at %0t", tag, $time);
            end else begin
                e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
                check({tag, "_upd_period"}, per, e.per);
                check({tag, "_upd_ovf"}, {31'd0, ov}, {31'd0, e.ovf});
            end
        end else begin
            check({tag, "_missed_upd"}, qs, 0);
            check({tag, "_ovf_alone"}, {31'd0, ov}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, "a", {20'd0, period_a}, valid_a, upd_a, ovf_a);
            mon(1, "b", {28'd0, period_b}, valid_b, upd_b, ovf_b);
        end
    end

    task automatic cyc(input logic c, input logic t);
        cen  = c;
        tick = t;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // One cen sample, preceded by cdiv-1 disabled clocks carrying junk ticks.
    task automatic sample(input logic t, input int cdiv);
        for (int k = 1; k < cdiv; k++) cyc(1'b0, 1'($urandom_range(0, 1)));
        cyc(1'b1, t);
    endtask

    task automatic gap(input int g, input int cdiv);
        repeat (g - 1) sample(1'b0, cdiv);
        sample(1'b1, cdiv);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        cen   = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;
        check("rst_period", {20'd0, period_a}, 32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_upd", {31'd0, upd_b}, 32'd0);

        // Tick every 5th cen sample.
        sample(1'b1, 1);
        repeat (5) gap(5, 1);
        check("t1_period_a", {20'd0, period_a}, 32'd5);
        check("t1_valid_a", {31'd0, valid_a}, 32'd1);
        check("t1_period_b", {28'd0, period_b}, 32'd5);

        // Tick held high: P=1.
        do_reset();
        repeat (8) sample(1'b1, 1);
        check("t2_period_a", {20'd0, period_a}, 32'd1);

        // Lock at 3, stop ticking: width-4 saturates after 15 samples, width-12 after 4095.
        do_reset();
        sample(1'b1, 1);
        repeat (4) gap(3, 1);
        repeat (14) sample(1'b0, 1);
        check("t3_b_pre_ovf", {31'd0, ovf_b}, 32'd0);
        sample(1'b0, 1);
        check("t3_b_ovf", {31'd0, ovf_b}, 32'd1);
        check("t3_b_upd", {31'd0, upd_b}, 32'd1);
        check("t3_b_period", {28'd0, period_b}, 32'd0);
        check("t3_a_period", {20'd0, period_a}, 32'd3);
        repeat (4079) sample(1'b0, 1);
        check("t3_a_pre_ovf", {31'd0, ovf_a}, 32'd0);
        sample(1'b0, 1);
        check("t3_a_ovf", {31'd0, ovf_a}, 32'd1);
        check("t3_a_valid", {31'd0, valid_a}, 32'd0);

        // cen 1 clk in 3, junk ticks while cen=0.
        do_reset();
        sample(1'b1, 3);
        repeat (4) gap(4, 3);
        check("t4_period_a", {20'd0, period_a}, 32'd4);

        // Gaps 5,6,6 then stray 7 then 6.
        do_reset();
        sample(1'b1, 1);
        gap(5, 1);
        gap(6, 1);
        gap(6, 1);
        check("t5_period_a", {20'd0, period_a}, 32'd6);
        gap(7, 1);
        gap(6, 1);
        check("t5_period_a_end", {20'd0, period_a}, 32'd6);

        // Reset mid-count while locked at 9.
        do_reset();
        sample(1'b1, 1);
        repeat (3) gap(9, 1);
        check("t6_locked", {20'd0, period_a}, 32'd9);
        repeat (4) sample(1'b0, 1);
        do_reset();
        check("t6_rst_period", {20'd0, period_a}, 32'd0);
        check("t6_rst_valid", {31'd0, valid_b}, 32'd0);
        sample(1'b1, 1);
        gap(9, 1);
        gap(9, 1);
        check("t6_relock", {20'd0, period_a}, 32'd9);

        // Randomized gaps with occasional jitter, slow cen and resets.
        do_reset();
        g = $urandom_range(1, 20);
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) g = $urandom_range(1, 20);
            gap(g, $urandom_range(1, 3));
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        repeat (20) sample(1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
